// File: rtl/ysyx_22041071_mem_arb.sv
// Shared memory port arbiter between instruction fetch (IF) and the
// load/store unit (LSU). One transaction is outstanding at a time. LSU has
// fixed priority unless IF has been waiting STARVE_LIM cycles. IF responses
// are swallowed when fetch is flushed while its transaction is in flight.
//
// Handshake rules (all interfaces): a transfer happens in a cycle where
// valid && ready are both 1. Request valids from IF/LSU may be dropped
// freely; mem_req_valid, once raised, holds with stable fields until
// mem_req_ready. Response valids are single-cycle pulses with no ready.
module ysyx_22041071_mem_arb #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    input  logic                if_flush,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,

    output logic                busy,
    output logic                owner,
    output logic                proto_err,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM_W = 4'(STARVE_LIM);

    state_t state, state_nxt;
    logic   owner_q;
    logic   drop;
    logic [3:0] wait_cnt;
    logic   proto_err_q;

    logic   if_elig;
    logic   starve;
    logic   grant_if;
    logic   grant_lsu;
    logic   rsp_fire;

    assign if_elig  = if_req_valid && !if_flush;
    assign starve   = (wait_cnt >= STARVE_LIM_W);
    assign rsp_fire = (state == ST_RESP) && mem_rsp_valid;

    // Arbitration: only IDLE grants; starving IF beats LSU, otherwise LSU first.
    always_comb begin
        grant_if  = 1'b0;
        grant_lsu = 1'b0;
        if (state == ST_IDLE) begin
            if (starve && if_elig) begin
                grant_if = 1'b1;
            end else if (lsu_req_valid) begin
                grant_lsu = 1'b1;
            end else if (if_elig) begin
                grant_if = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> REQ on grant, REQ -> RESP on accept, RESP -> IDLE on response.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_if || grant_lsu) state_nxt = ST_REQ;
            ST_REQ:  if (mem_req_ready)         state_nxt = ST_RESP;
            ST_RESP: if (mem_rsp_valid)         state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: readies come only from state and IF/LSU inputs, never from mem_req_ready.
    always_comb begin
        if_req_ready  = grant_if;
        lsu_req_ready = grant_lsu;
        mem_req_valid = (state == ST_REQ);
        busy          = (state != ST_IDLE);
        if_rsp_valid  = rsp_fire && !owner_q && !drop && !if_flush;
        lsu_rsp_valid = rsp_fire && owner_q;
    end

    assign if_rsp_rdata  = mem_rsp_rdata;
    assign lsu_rsp_rdata = mem_rsp_rdata;
    assign owner         = owner_q;
    assign proto_err     = proto_err_q;
    assign dbg_state     = state;

    // Latch the winning request so the downstream fields stay stable through REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q       <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else if (grant_lsu) begin
            owner_q       <= 1'b1;
            mem_req_addr  <= lsu_req_addr;
            mem_req_wen   <= lsu_req_wen;
            mem_req_wdata <= lsu_req_wdata;
            mem_req_wmask <= lsu_req_wmask;
        end else if (grant_if) begin
            owner_q       <= 1'b0;
            mem_req_addr  <= if_req_addr;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end
    end

    // Drop flag: a flush during an in-flight IF fetch makes its response silent.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop <= 1'b0;
        end else if (rsp_fire) begin
            drop <= 1'b0;
        end else if ((state != ST_IDLE) && !owner_q && if_flush) begin
            drop <= 1'b1;
        end
    end

    // Starvation counter: cycles IF has been asking without a grant, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (!if_req_valid || grant_if) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Sticky protocol error: a response arrived while none was outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err_q <= 1'b0;
        end else if (mem_rsp_valid && (state != ST_RESP)) begin
            proto_err_q <= 1'b1;
        end
    end

endmodule

// File: doc/ysyx_22041071_mem_arb.md
Name: ysyx_22041071_mem_arb

Overview:
Arbitrates a single shared memory port between instruction fetch (IF) and the load/store unit (LSU) of the 5-stage pipeline. Exactly one transaction is outstanding at a time. LSU has fixed priority, with a starvation guard for IF. IF responses are dropped when the pipeline flushes fetch after a jal/jalr/branch redirect.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
STARVE_LIM, 4, consecutive cycles IF waits before IF wins over LSU (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
if_req_valid  in  1  IF read request
if_req_ready  out  1  IF request accepted this cycle
if_req_addr  in  ADDR_W  fetch address
if_flush  in  1  discard any pending IF response
if_rsp_valid  out  1  IF read data valid, 1-cycle pulse
if_rsp_rdata  out  DATA_W  fetch data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted
lsu_req_addr  in  ADDR_W  address
lsu_req_wen  in  1  1 = write
lsu_req_wdata  in  DATA_W  write data
lsu_req_wmask  in  DATA_W/8  byte mask
lsu_rsp_valid  out  1  LSU read data / write ack, 1-cycle pulse
lsu_rsp_rdata  out  DATA_W  load data
mem_req_valid  out  1  downstream request
mem_req_ready  in  1  downstream accepts
mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
mem_rsp_valid  in  1  downstream response
mem_rsp_rdata  in  DATA_W  response data
busy  out  1  state != IDLE
owner  out  1  0 = IF, 1 = LSU (valid when busy)
proto_err  out  1  sticky: mem_rsp_valid seen outside RESP

Behaviour:
- Reset: state = IDLE, owner = 0, drop = 0, wait_cnt = 0, proto_err = 0. All valid/ready outputs are 0. Latched request fields are 0.
- FSM states: IDLE, REQ, RESP.
- IDLE, arbitration (combinational):
  - IF is eligible when if_req_valid && !if_flush.
  - If wait_cnt >= STARVE_LIM and IF is eligible, IF wins.
  - Otherwise LSU wins if lsu_req_valid; else IF wins if eligible.
- IDLE, on a win: assert the winner's req_ready this cycle; the loser's ready stays 0. Latch addr/wen/wdata/wmask (IF: wen = 0, wmask = 0) and owner, then go to REQ. No request means stay in IDLE.
- req_ready is 0 in REQ and RESP.
- REQ: mem_req_valid = 1 with stable latched fields. On mem_req_ready go to RESP; otherwise hold. A request is never retracted.
- RESP: mem_req_valid = 0. On mem_rsp_valid:
  - Drive owner's rsp_valid = 1 in the same cycle, with rsp_rdata = mem_rsp_rdata (combinational pass-through). Writes also get an ack pulse.
  - Exception: when owner = IF and drop = 1 (or if_flush is high that same cycle), if_rsp_valid is suppressed.
  - Go to IDLE and clear drop.
- rsp_rdata outputs equal mem_rsp_rdata at all times; only the valids are gated.
- Drop flag: set when if_flush = 1 while busy && owner = IF, in REQ or RESP. The downstream transaction still completes and its response is consumed silently. if_flush has no effect on an LSU transaction.
- Latency:
  - Accept in cycle N (IDLE); mem_req_valid in N+1.
  - If mem_req_ready in N+1, the earliest response is N+2.
  - The next accept is at N+3 at the earliest (back-to-back throughput: 1 transaction per 3 cycles).
- wait_cnt:
  - Increments (saturating at 15) each cycle if_req_valid = 1 and IF is not granted.
  - Clears when IF is granted or if_req_valid = 0.
- proto_err: set when mem_rsp_valid = 1 in IDLE or REQ; that response is ignored. Cleared only by reset.
- Reset mid-transaction returns to IDLE immediately; an outstanding downstream response arriving afterwards sets proto_err.
- No combinational path from mem_req_ready to any req_ready.

Test Plan:
- Single IF read: if_req_valid with addr 0x8000_0000, mem_req_ready = 1, response 0x00000013 two cycles later. Expect if_req_ready pulse in N, mem_req_valid in N+1, if_rsp_valid with 0x13 in N+2, busy 1 for N+1..N+2.
- Simultaneous requests: IF (0x8000_0004) and LSU store (addr 0x8000_1000, wdata 0xDEAD, wmask 0xFF) asserted together. Expect LSU granted first with mem_req_wen = 1, lsu_rsp_valid ack; IF granted in the next IDLE cycle.
- Starvation: LSU requests every cycle, IF held valid, STARVE_LIM = 4. Expect IF granted once wait_cnt reaches 4, and wait_cnt cleared to 0.
- Flush: IF granted, if_flush pulsed in REQ, mem_req_ready delayed 3 cycles. Expect the mem transaction to complete, if_rsp_valid stays 0, state returns to IDLE, drop cleared.
- Backpressure: mem_req_ready low for 5 cycles on an LSU load. Expect addr/wdata/wmask stable and mem_req_valid held, both req_ready low, then a normal response.
- Protocol error and reset: mem_rsp_valid pulsed in IDLE, expect proto_err = 1 and no rsp_valid. Reset asserted during RESP: expect IDLE, busy = 0, proto_err = 0 the next cycle.
